// File: rtl/pmp_scan_ctrl_if.sv
// rtl/pmp_scan_ctrl_if.sv - request/response and PMP CSR bundle for pmp_scan_ctrl
//
// Purpose: groups the check-request handshake, the PMP CSR view and the
// response signals of pmp_scan_ctrl into one interface.
// Modports:
//   master - requester (MMU/PTW): drives request, CSR arrays, CfgWrite, Flush
//   slave  - pmp_scan_ctrl: drives ReqReady and the response signals
// Signals:
//   ReqValid/ReqReady            request handshake
//   PhysicalAddress, Size,       access being checked
//   AccessType, PrivilegeMode
//   PMPCFG_ARRAY_REGW            cfg byte per entry
//   PMPADDR_ARRAY_REGW           pmpaddr per entry (units of 4 bytes)
//   CfgWrite, Flush              CSR-written pulse, abandon request
//   RespValid, Fault,            response pulse and results
//   MatchValid, MatchIdx
interface pmp_scan_ctrl_if #(
  parameter int PA_BITS     = 56,
  parameter int PMP_ENTRIES = 16
);
  // Zero-entry builds still need non-empty vectors.
  localparam int NE   = (PMP_ENTRIES == 0) ? 1 : PMP_ENTRIES;
  localparam int IDXW = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1;

  logic                           ReqValid;
  logic                           ReqReady;
  logic [PA_BITS-1:0]             PhysicalAddress;
  logic [1:0]                     Size;
  logic [2:0]                     AccessType;
  logic [1:0]                     PrivilegeMode;
  logic [NE-1:0][7:0]             PMPCFG_ARRAY_REGW;
  logic [NE-1:0][PA_BITS-3:0]     PMPADDR_ARRAY_REGW;
  logic                           CfgWrite;
  logic                           Flush;
  logic                           RespValid;
  logic                           Fault;
  logic                           MatchValid;
  logic [IDXW-1:0]                MatchIdx;

  modport master (
    output ReqValid, PhysicalAddress, Size, AccessType, PrivilegeMode,
           PMPCFG_ARRAY_REGW, PMPADDR_ARRAY_REGW, CfgWrite, Flush,
    input  ReqReady, RespValid, Fault, MatchValid, MatchIdx
  );

  modport slave (
    input  ReqValid, PhysicalAddress, Size, AccessType, PrivilegeMode,
           PMPCFG_ARRAY_REGW, PMPADDR_ARRAY_REGW, CfgWrite, Flush,
    output ReqReady, RespValid, Fault, MatchValid, MatchIdx
  );
endinterface

// File: rtl/pmp_scan_ctrl.sv
// rtl/pmp_scan_ctrl.sv - iterative PMP checker, one entry evaluated per cycle
//
// Purpose: accepts one physical-access check at a time, walks the PMP entries
// in priority order (one per cycle), stops at the first match and returns a
// fault/permit response as a one-cycle RespValid pulse.
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high reset
//   bus    - pmp_scan_ctrl_if.slave (request, CSR view, CfgWrite/Flush, response)
// Optional feature macro: PMP_HIT_CACHE_EN - one-entry result cache; a repeat
// of the last checked request answers one cycle after acceptance.
module pmp_scan_ctrl #(
  parameter int PA_BITS     = 56,
  parameter int PMP_ENTRIES = 16
) (
  input  logic              clk,
  input  logic              reset,
  pmp_scan_ctrl_if.slave    bus
);
  localparam int NE   = (PMP_ENTRIES == 0) ? 1 : PMP_ENTRIES;
  localparam int IDXW = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1;
  localparam int WAW  = PA_BITS - 2;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;

  state_t              state_q;
  logic [IDXW-1:0]     idx_q;
  logic                ready_q, resp_valid_q, fault_q, match_valid_q;
  logic [IDXW-1:0]     match_idx_q;

  // Latched request
  logic [PA_BITS-1:0]  pa_q;
  logic [1:0]          size_q;
  logic [2:0]          acc_q;
  logic [1:0]          priv_q;

`ifdef PMP_HIT_CACHE_EN
  logic                c_valid_q;
  logic [WAW-1:0]      c_wa_q;
  logic [1:0]          c_size_q;
  logic [2:0]          c_acc_q;
  logic [1:0]          c_priv_q;
  logic                c_fault_q, c_mv_q;
  logic [IDXW-1:0]     c_idx_q;
  logic                c_hit;
`endif

  // Per-entry evaluation of the entry at idx_q
  logic [7:0]          cfg_sel;
  logic [WAW-1:0]      addr_sel, addr_prev, napot_mask, wa, lb_wa;
  logic [PA_BITS-1:0]  lb;
  logic                ent_hit, ent_cross, enforce, perm_ok, hit_fault, miss_fault, last_ent;
  logic                unused_bits;

  always_comb begin
    cfg_sel    = bus.PMPCFG_ARRAY_REGW[idx_q];
    addr_sel   = bus.PMPADDR_ARRAY_REGW[idx_q];
    addr_prev  = (idx_q == '0) ? '0 : bus.PMPADDR_ARRAY_REGW[idx_q - IDXW'(1)];
    wa         = pa_q[PA_BITS-1:2];
    lb         = pa_q + (PA_BITS'(1) << size_q) - PA_BITS'(1);
    lb_wa      = lb[PA_BITS-1:2];
    // Trailing ones of pmpaddr plus the next bit: addr ^ (addr+1) is a mask
    // of exactly k+1 low ones, i.e. the word offset bits inside the region.
    napot_mask = addr_sel ^ (addr_sel + WAW'(1));
    ent_hit    = 1'b0;
    ent_cross  = 1'b0;
    case (cfg_sel[4:3])
      2'd1: begin
        ent_hit   = (wa >= addr_prev) && (wa < addr_sel);
        ent_cross = (lb_wa >= addr_sel);
      end
      2'd2: begin
        ent_hit   = (wa == addr_sel);
        ent_cross = (lb_wa != addr_sel);
      end
      2'd3: begin
        ent_hit   = ((wa ^ addr_sel) & ~napot_mask) == '0;
        ent_cross = ((lb_wa ^ addr_sel) & ~napot_mask) != '0;
      end
      default: ;
    endcase
    enforce     = (priv_q != 2'b11) | cfg_sel[7];
    perm_ok     = |(acc_q & cfg_sel[2:0]);
    hit_fault   = enforce & (ent_cross | ~perm_ok);
    miss_fault  = (priv_q != 2'b11);
    last_ent    = (idx_q == IDXW'(NE - 1));
    unused_bits = ^{cfg_sel[6:5], lb[1:0]};
  end

`ifdef PMP_HIT_CACHE_EN
  // A CSR write or flush in the same cycle invalidates, so it cannot hit.
  assign c_hit = c_valid_q && !bus.CfgWrite && !bus.Flush &&
                 (bus.PhysicalAddress[PA_BITS-1:2] == c_wa_q) &&
                 (bus.Size == c_size_q) && (bus.AccessType == c_acc_q) &&
                 (bus.PrivilegeMode == c_priv_q);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      ready_q       <= 1'b1;
      resp_valid_q  <= 1'b0;
      fault_q       <= 1'b0;
      match_valid_q <= 1'b0;
      match_idx_q   <= '0;
      pa_q          <= '0;
      size_q        <= '0;
      acc_q         <= '0;
      priv_q        <= '0;
`ifdef PMP_HIT_CACHE_EN
      c_valid_q     <= 1'b0;
      c_wa_q        <= '0;
      c_size_q      <= '0;
      c_acc_q       <= '0;
      c_priv_q      <= '0;
      c_fault_q     <= 1'b0;
      c_mv_q        <= 1'b0;
      c_idx_q       <= '0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.ReqValid) begin
            pa_q    <= bus.PhysicalAddress;
            size_q  <= bus.Size;
            acc_q   <= bus.AccessType;
            priv_q  <= bus.PrivilegeMode;
            idx_q   <= '0;
            ready_q <= 1'b0;
            if (PMP_ENTRIES == 0) begin
              state_q       <= S_RESP;
              resp_valid_q  <= 1'b1;
              match_valid_q <= 1'b0;
              match_idx_q   <= '0;
              fault_q       <= (bus.PrivilegeMode != 2'b11);
`ifdef PMP_HIT_CACHE_EN
            end else if (c_hit) begin
              state_q       <= S_RESP;
              resp_valid_q  <= 1'b1;
              match_valid_q <= c_mv_q;
              match_idx_q   <= c_idx_q;
              fault_q       <= c_fault_q;
`endif
            end else begin
              state_q <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (bus.Flush) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end else if (bus.CfgWrite) begin
            idx_q <= '0;  // CSRs changed under us: rescan with the same request
          end else if (ent_hit) begin
            state_q       <= S_RESP;
            resp_valid_q  <= 1'b1;
            match_valid_q <= 1'b1;
            match_idx_q   <= idx_q;
            fault_q       <= hit_fault;
          end else if (last_ent) begin
            state_q       <= S_RESP;
            resp_valid_q  <= 1'b1;
            match_valid_q <= 1'b0;
            fault_q       <= miss_fault;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
`ifdef PMP_HIT_CACHE_EN
          c_valid_q <= 1'b1;
          c_wa_q    <= pa_q[PA_BITS-1:2];
          c_size_q  <= size_q;
          c_acc_q   <= acc_q;
          c_priv_q  <= priv_q;
          c_fault_q <= fault_q;
          c_mv_q    <= match_valid_q;
          c_idx_q   <= match_idx_q;
`endif
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
`ifdef PMP_HIT_CACHE_EN
      // Invalidation overrides the RESP-cycle write above.
      if (bus.CfgWrite || bus.Flush) c_valid_q <= 1'b0;
`endif
    end
  end

  // A flush arriving in the RESP cycle suppresses the pending pulse.
  assign bus.RespValid  = resp_valid_q & ~bus.Flush;
  assign bus.ReqReady   = ready_q;
  assign bus.Fault      = fault_q;
  assign bus.MatchValid = match_valid_q;
  assign bus.MatchIdx   = match_idx_q;
endmodule

// File: tb/tb_pmp_scan_ctrl.sv
// tb/tb_pmp_scan_ctrl.sv - directed self-checking bench for pmp_scan_ctrl
module tb_pmp_scan_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  pmp_scan_ctrl_if #(.PA_BITS(56), .PMP_ENTRIES(16)) bus ();

  pmp_scan_ctrl #(.PA_BITS(56), .PMP_ENTRIES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_cfg();
    bus.PMPCFG_ARRAY_REGW  = '0;
    bus.PMPADDR_ARRAY_REGW = '0;
  endtask

  task automatic pulse_cfgwrite();
    @(negedge clk);
    bus.CfgWrite = 1'b1;
    @(negedge clk);
    bus.CfgWrite = 1'b0;
  endtask

  // Issues one request from IDLE; lat is the response cycle relative to the
  // acceptance edge t0 (RespValid seen right after edge t0+m => t0+m+1).
  // cw_at > 0 pulses CfgWrite so that it is sampled at edge t0+cw_at.
  task automatic run_req(input logic [55:0] pa, input logic [1:0] sz,
                         input logic [2:0] acc, input logic [1:0] priv,
                         input int cw_at, output int lat, output logic flt,
                         output logic mv, output logic [3:0] midx);
    int m;
    @(negedge clk);
    bus.ReqValid        = 1'b1;
    bus.PhysicalAddress = pa;
    bus.Size            = sz;
    bus.AccessType      = acc;
    bus.PrivilegeMode   = priv;
    @(posedge clk);
    #1;
    bus.ReqValid = 1'b0;
    m = 0;
    while (!bus.RespValid && m < 100) begin
      if (cw_at > 0 && m == cw_at - 1) bus.CfgWrite = 1'b1;
      @(posedge clk);
      #1;
      bus.CfgWrite = 1'b0;
      m++;
    end
    lat  = m + 1;
    flt  = bus.Fault;
    mv   = bus.MatchValid;
    midx = bus.MatchIdx;
    @(negedge clk);
  endtask

  int         lat, cnt;
  logic       flt, mv;
  logic [3:0] midx;

  initial begin
    reset              = 1'b1;
    bus.ReqValid       = 1'b0;
    bus.PhysicalAddress = '0;
    bus.Size           = '0;
    bus.AccessType     = '0;
    bus.PrivilegeMode  = '0;
    bus.CfgWrite       = 1'b0;
    bus.Flush          = 1'b0;
    clear_cfg();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check_eq("rst_ready", bus.ReqReady, 1);
    check_eq("rst_respvalid", bus.RespValid, 0);
    check_eq("rst_fault", bus.Fault, 0);
    check_eq("rst_matchvalid", bus.MatchValid, 0);
    check_eq("rst_matchidx", bus.MatchIdx, 0);

    // 1. TOR hit at entry 0, U-mode read
    clear_cfg();
    bus.PMPCFG_ARRAY_REGW[0]  = 8'h09;
    bus.PMPADDR_ARRAY_REGW[0] = 54'h400;
    pulse_cfgwrite();
    run_req(56'h800, 2'd2, 3'b001, 2'b00, 0, lat, flt, mv, midx);
    check_eq("tor_lat", lat, 2);
    check_eq("tor_idx", midx, 0);
    check_eq("tor_fault", flt, 0);
    check_eq("tor_mv", mv, 1);
    @(posedge clk);
    #1;
    check_eq("tor_pulse_once", bus.RespValid, 0);
    check_eq("tor_ready_back", bus.ReqReady, 1);

    // 2. NAPOT cross at entry 3, S-mode write
    clear_cfg();
    bus.PMPCFG_ARRAY_REGW[3]  = 8'h1A;
    bus.PMPADDR_ARRAY_REGW[3] = 54'h41FF;
    pulse_cfgwrite();
    run_req(56'h10FFC, 2'd3, 3'b010, 2'b01, 0, lat, flt, mv, midx);
    check_eq("napot_lat", lat, 5);
    check_eq("napot_idx", midx, 3);
    check_eq("napot_fault", flt, 1);
    check_eq("napot_mv", mv, 1);
    // Same region, access fully inside and permitted
    run_req(56'h10FF8, 2'd3, 3'b010, 2'b01, 0, lat, flt, mv, midx);
    check_eq("napot_in_fault", flt, 0);
    check_eq("napot_in_idx", midx, 3);
    repeat (4) @(negedge clk);
    check_eq("hold_idx", bus.MatchIdx, 3);

    // 3. No match, all OFF
    clear_cfg();
    pulse_cfgwrite();
    run_req(56'h8000_0000, 2'd2, 3'b100, 2'b11, 0, lat, flt, mv, midx);
    check_eq("miss_m_lat", lat, 17);
    check_eq("miss_m_fault", flt, 0);
    check_eq("miss_m_mv", mv, 0);
    run_req(56'h8000_0000, 2'd2, 3'b100, 2'b00, 0, lat, flt, mv, midx);
    check_eq("miss_u_lat", lat, 17);
    check_eq("miss_u_fault", flt, 1);
    check_eq("miss_u_mv", mv, 0);

    // 4. Lock bit enforces in M-mode
    clear_cfg();
    bus.PMPCFG_ARRAY_REGW[0]  = 8'h8C;
    bus.PMPADDR_ARRAY_REGW[0] = 54'h400;
    pulse_cfgwrite();
    run_req(56'h100, 2'd2, 3'b010, 2'b11, 0, lat, flt, mv, midx);
    check_eq("lock_fault", flt, 1);
    bus.PMPCFG_ARRAY_REGW[0] = 8'h0C;
    pulse_cfgwrite();
    run_req(56'h100, 2'd2, 3'b010, 2'b11, 0, lat, flt, mv, midx);
    check_eq("nolock_fault", flt, 0);

    // 5a. CfgWrite in cycle t0+3 restarts the scan: 3 cycles later than scenario 2
    clear_cfg();
    bus.PMPCFG_ARRAY_REGW[3]  = 8'h1A;
    bus.PMPADDR_ARRAY_REGW[3] = 54'h41FF;
    pulse_cfgwrite();
    run_req(56'h10FFC, 2'd3, 3'b010, 2'b01, 3, lat, flt, mv, midx);
    check_eq("cw_lat", lat, 8);
    check_eq("cw_idx", midx, 3);
    check_eq("cw_fault", flt, 1);

    // 5b. Flush in SCAN
    @(negedge clk);
    bus.ReqValid        = 1'b1;
    bus.PhysicalAddress = 56'h10FFC;
    bus.Size            = 2'd3;
    bus.AccessType      = 3'b010;
    bus.PrivilegeMode   = 2'b01;
    @(posedge clk);
    #1;
    bus.ReqValid = 1'b0;
    @(posedge clk);
    #1;
    bus.Flush = 1'b1;
    @(posedge clk);
    #1;
    bus.Flush = 1'b0;
    check_eq("flush_ready", bus.ReqReady, 1);
    check_eq("flush_resp", bus.RespValid, 0);
    cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.RespValid) cnt++;
    end
    check_eq("flush_no_resp", cnt, 0);

    // Reset mid-scan abandons the request
    @(negedge clk);
    bus.ReqValid = 1'b1;
    @(posedge clk);
    #1;
    bus.ReqValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rstmid_ready", bus.ReqReady, 1);
    cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.RespValid) cnt++;
    end
    check_eq("rstmid_no_resp", cnt, 0);

    // 6. Repeat of scenario 2: cached answer when the cache is built in
    run_req(56'h10FFC, 2'd3, 3'b010, 2'b01, 0, lat, flt, mv, midx);
    check_eq("rep1_lat", lat, 5);
    run_req(56'h10FFC, 2'd3, 3'b010, 2'b01, 0, lat, flt, mv, midx);
`ifdef PMP_HIT_CACHE_EN
    check_eq("rep2_lat", lat, 1);
`else
    check_eq("rep2_lat", lat, 5);
`endif
    check_eq("rep2_idx", midx, 3);
    check_eq("rep2_fault", flt, 1);
    pulse_cfgwrite();
    run_req(56'h10FFC, 2'd3, 3'b010, 2'b01, 0, lat, flt, mv, midx);
    check_eq("rep3_lat", lat, 5);
    check_eq("rep3_fault", flt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
